// File: rtl/c1_pkg.sv
// Shared types for the C1 bus responder: opcodes, FSM states and small
// opcode-classification helpers used by the responder datapath.
package c1_pkg;

    typedef enum logic [2:0] {
        C1_NOP  = 3'd0,
        C1_RD8  = 3'd1,
        C1_RD16 = 3'd2,
        C1_RD32 = 3'd3,
        C1_INV  = 3'd4,
        C1_WR8  = 3'd5,
        C1_WR16 = 3'd6,
        C1_WR32 = 3'd7
    } c1_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR2 = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP0 = 3'd4,
        ST_RESP1 = 3'd5
    } c1_rsp_state_t;

    // Response opcode shares its encoding with WR32.
    localparam logic [2:0] C1_RESP = 3'd7;

    // Reads are the only ops for which the responder takes ownership of data.
    function automatic logic c1_is_read(input c1_cmd_t op);
        return (op == C1_RD8) || (op == C1_RD16) || (op == C1_RD32);
    endfunction

    // Natural alignment: 16-bit ops on even bytes, 32-bit ops on 4-byte bounds.
    function automatic logic c1_misaligned(input c1_cmd_t op, input logic [1:0] a);
        return (((op == C1_RD16) || (op == C1_WR16)) && a[0]) ||
               (((op == C1_RD32) || (op == C1_WR32)) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/c1_bus_responder_if.sv
// Valid/ready request channel between the C1 responder and the cache core.
// master = responder (issues requests), slave = cache core.
interface c1_bus_responder_if #(
    parameter int MEM_ADDR_SIZE = 19,
    parameter int BUS_SIZE      = 16
);
    logic                       req_valid;
    logic                       req_ready;
    logic [2:0]                 req_cmd;
    logic [MEM_ADDR_SIZE-1:0]   req_addr;
    logic [2*BUS_SIZE-1:0]      req_wdata;
    logic                       resp_valid;
    logic [2*BUS_SIZE-1:0]      resp_rdata;

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/c1_tristate_drv.sv
// Per-bit tri-state pad driver: drives val when en is high, else releases to 'z.
module c1_tristate_drv #(
    parameter int W = 1
) (
    input  logic         en,
    input  logic [W-1:0] val,
    inout  wire  [W-1:0] pad
);
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign pad[gi] = en ? val[gi] : 1'bz;
    end
endmodule

// File: rtl/c1_bus_responder.sv
// C1 bus responder (cache side). Decodes the two-beat C1 command from the CPU,
// issues one valid/ready request to the cache core, then returns the RESP
// opcode (and read data for read ops) on the shared tri-state bus.
// Optional feature macro: C1_ALIGN_CHECK_EN (misaligned 16/32-bit accesses are
// answered locally with all-ones data and an align_err pulse).
module c1_bus_responder
    import c1_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                    data,
    inout  wire  [2:0]                             command,
    c1_bus_responder_if.master                     core,
    output logic                                   busy
`ifdef C1_ALIGN_CHECK_EN
    ,
    output logic                                   align_err
`endif
);
    localparam int TAG_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int W2    = 2 * BUS_SIZE;

    c1_rsp_state_t               state_q, state_d;
    c1_cmd_t                     op_q, op_d;
    logic [TAG_W-1:0]            tag_q, tag_d;
    logic [CACHE_OFFSET_SIZE-1:0] off_q, off_d;
    logic [BUS_SIZE-1:0]         beat1_q, beat1_d;
    logic [BUS_SIZE-1:0]         beat2_q, beat2_d;
    logic [W2-1:0]               rdata_q, rdata_d;
    logic [BUS_SIZE-1:0]         data_out_q, data_out_d;
    logic                        req_valid_q, req_valid_d;
    logic                        busy_q, busy_d;
    logic                        cmd_en_q, cmd_en_d;
    logic                        data_en_q, data_en_d;
    logic                        turn_q, turn_d;
`ifdef C1_ALIGN_CHECK_EN
    logic                        align_err_q, align_err_d;
`endif

    // Next-state and registered-output computation for the responder FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tag_d       = tag_q;
        off_d       = off_q;
        beat1_d     = beat1_q;
        beat2_d     = beat2_q;
        rdata_d     = rdata_q;
        data_out_d  = data_out_q;
        req_valid_d = req_valid_q;
        busy_d      = busy_q;
        cmd_en_d    = cmd_en_q;
        data_en_d   = data_en_q;
        turn_d      = turn_q;
`ifdef C1_ALIGN_CHECK_EN
        align_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // The first IDLE edge after a response is a bus turnaround:
                // whatever is on command then is ignored.
                if (turn_q) begin
                    turn_d = 1'b0;
                end else if (command inside {[3'd1:3'd7]}) begin
                    op_d    = c1_cmd_t'(command);
                    tag_d   = address;
                    beat1_d = data;
                    busy_d  = 1'b1;
                    state_d = ST_ADDR2;
                end
            end
            ST_ADDR2: begin
                off_d   = address[CACHE_OFFSET_SIZE-1:0];
                beat2_d = data;
`ifdef C1_ALIGN_CHECK_EN
                if (c1_misaligned(op_q, address[1:0])) begin
                    rdata_d     = '1;
                    data_out_d  = '1;
                    cmd_en_d    = 1'b1;
                    data_en_d   = c1_is_read(op_q);
                    align_err_d = 1'b1;
                    state_d     = ST_RESP0;
                end else begin
                    req_valid_d = 1'b1;
                    state_d     = ST_REQ;
                end
`else
                req_valid_d = 1'b1;
                state_d     = ST_REQ;
`endif
            end
            ST_REQ: begin
                if (core.req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core.resp_valid) begin
                    rdata_d   = core.resp_rdata;
                    cmd_en_d  = 1'b1;
                    data_en_d = c1_is_read(op_q);
                    if (op_q == C1_RD8) begin
                        data_out_d      = '0;
                        data_out_d[7:0] = core.resp_rdata[7:0];
                    end else begin
                        data_out_d = core.resp_rdata[BUS_SIZE-1:0];
                    end
                    state_d = ST_RESP0;
                end
            end
            ST_RESP0: begin
                if (op_q == C1_RD32) begin
                    data_out_d = rdata_q[W2-1:BUS_SIZE];
                    state_d    = ST_RESP1;
                end else begin
                    cmd_en_d  = 1'b0;
                    data_en_d = 1'b0;
                    busy_d    = 1'b0;
                    turn_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RESP1: begin
                cmd_en_d  = 1'b0;
                data_en_d = 1'b0;
                busy_d    = 1'b0;
                turn_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; async reset also drops the pad enables so the bus is
    // released in the same timestep as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= C1_NOP;
            tag_q       <= '0;
            off_q       <= '0;
            beat1_q     <= '0;
            beat2_q     <= '0;
            rdata_q     <= '0;
            data_out_q  <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_en_q    <= 1'b0;
            data_en_q   <= 1'b0;
            turn_q      <= 1'b0;
`ifdef C1_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            off_q       <= off_d;
            beat1_q     <= beat1_d;
            beat2_q     <= beat2_d;
            rdata_q     <= rdata_d;
            data_out_q  <= data_out_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            cmd_en_q    <= cmd_en_d;
            data_en_q   <= data_en_d;
            turn_q      <= turn_d;
`ifdef C1_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    assign core.req_valid = req_valid_q;
    assign core.req_cmd   = op_q;
    assign core.req_addr  = {tag_q, off_q};
    assign core.req_wdata = (op_q == C1_WR32) ? {beat2_q, beat1_q}
                                              : {{BUS_SIZE{1'b0}}, beat1_q};
    assign busy           = busy_q;
`ifdef C1_ALIGN_CHECK_EN
    assign align_err      = align_err_q;
`endif

    c1_tristate_drv #(.W(BUS_SIZE)) u_data_drv (
        .en  (data_en_q),
        .val (data_out_q),
        .pad (data)
    );

    c1_tristate_drv #(.W(3)) u_cmd_drv (
        .en  (cmd_en_q),
        .val (C1_RESP),
        .pad (command)
    );

endmodule

// File: tb/tb_c1_bus_responder.sv
// Self-checking bench for c1_bus_responder. Bus lines are pulled low so a
// released (undriven) bus reads as zero. Expected responses come from a
// transaction-level model of the C1 rules inside do_txn.
module tb_c1_bus_responder;
    localparam int MA = 19;
    localparam int BS = 16;
    localparam int OS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [MA-OS-1:0] address;
    tri0  [BS-1:0]    data;
    tri0  [2:0]       command;
    logic             cpu_data_en, cpu_cmd_en;
    logic [BS-1:0]    cpu_data;
    logic [2:0]       cpu_cmd;
    logic             busy;
`ifdef C1_ALIGN_CHECK_EN
    logic             align_err;
`endif

    assign data    = cpu_data_en ? cpu_data : 'z;
    assign command = cpu_cmd_en  ? cpu_cmd  : 'z;

    c1_bus_responder_if #(.MEM_ADDR_SIZE(MA), .BUS_SIZE(BS)) core_if ();

    c1_bus_responder #(
        .MEM_ADDR_SIZE(MA), .BUS_SIZE(BS), .CACHE_OFFSET_SIZE(OS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .data      (data),
        .command   (command),
        .core      (core_if),
        .busy      (busy)
`ifdef C1_ALIGN_CHECK_EN
        ,
        .align_err (align_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full C1 transaction. abort: 0 none, 1 reset in first WAIT cycle,
    // 2 reset during the last RESP cycle.
    task automatic do_txn(input int op, input logic [18:0] addr,
                          input logic [15:0] w1, input logic [15:0] w2,
                          input logic [31:0] rd, input int rdy_dly,
                          input int core_dly, input int abort);
        bit          mis;
        bit          is_rd;
        int          nb;
        logic [31:0] rdm;
        logic [31:0] exp_wdata;
        logic [15:0] exp_beat [2];
        logic [31:0] rnd;

        mis = 1'b0;
`ifdef C1_ALIGN_CHECK_EN
        mis = ((op == 2 || op == 6) && addr[0]) ||
              ((op == 3 || op == 7) && (addr[1:0] != 2'b00));
`endif
        is_rd       = (op >= 1 && op <= 3);
        nb          = (op == 3) ? 2 : 1;
        rdm         = mis ? 32'hFFFF_FFFF : rd;
        exp_wdata   = (op == 7) ? {w2, w1} : {16'h0000, w1};
        exp_beat[0] = (op == 1) ? {8'h00, rdm[7:0]} : rdm[15:0];
        exp_beat[1] = rdm[31:16];
        if (!is_rd) begin
            exp_beat[0] = 16'h0000;
            exp_beat[1] = 16'h0000;
        end
        $display("txn op=%0d addr=%05h w=%04h_%04h rd=%08h rdy=%0d core=%0d abort=%0d",
                 op, addr, w2, w1, rd, rdy_dly, core_dly, abort);

        // Beat 1: opcode, tag|set, first data beat
        @(posedge clk); #1;
        cpu_cmd_en  = 1'b1;
        cpu_cmd     = op[2:0];
        cpu_data_en = 1'b1;
        cpu_data    = w1;
        address     = addr[18:4];
        @(negedge clk);
        chk("pre_capture_busy", 32'(busy), 32'd0);

        // Beat 2: offset in low bits (upper bits are noise), second data beat
        @(posedge clk); #1;
        rnd         = $urandom();
        cpu_cmd_en  = 1'b0;
        cpu_data    = w2;
        address     = {rnd[10:0], addr[3:0]};
        @(negedge clk);
        chk("addr2_busy", 32'(busy), 32'd1);
        chk("addr2_req_valid", 32'(core_if.req_valid), 32'd0);

        @(posedge clk); #1;
        cpu_data_en = 1'b0;
        address     = rnd[26:12];

        if (!mis) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                core_if.req_ready = (k == rdy_dly);
                @(negedge clk);
                chk("req_valid", 32'(core_if.req_valid), 32'd1);
                chk("req_cmd", 32'(core_if.req_cmd), 32'(op));
                chk("req_addr", 32'(core_if.req_addr), 32'(addr));
                chk("req_wdata", core_if.req_wdata, exp_wdata);
                chk("req_cmd_bus", 32'(command), 32'd0);
                @(posedge clk); #1;
            end
            core_if.req_ready = 1'b0;
            for (int j = 0; j <= core_dly; j++) begin
                core_if.resp_valid = (j == core_dly);
                core_if.resp_rdata = (j == core_dly) ? rd : $urandom();
                @(negedge clk);
                chk("wait_req_valid", 32'(core_if.req_valid), 32'd0);
                chk("wait_cmd_bus", 32'(command), 32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
                if (abort == 1) begin
                    core_if.resp_valid = 1'b0;
                    #1 rst_n = 1'b0;
                    #1;
                    chk("rst_wait_cmd", 32'(command), 32'd0);
                    chk("rst_wait_data", 32'(data), 32'd0);
                    chk("rst_wait_busy", 32'(busy), 32'd0);
                    chk("rst_wait_req_valid", 32'(core_if.req_valid), 32'd0);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
                @(posedge clk); #1;
            end
            core_if.resp_valid = 1'b0;
            core_if.resp_rdata = $urandom();
        end

        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            chk("resp_cmd", 32'(command), 32'd7);
            chk("resp_data", 32'(data), 32'(exp_beat[b]));
            chk("resp_busy", 32'(busy), 32'd1);
            chk("resp_req_valid", 32'(core_if.req_valid), 32'd0);
`ifdef C1_ALIGN_CHECK_EN
            chk("resp_align_err", 32'(align_err), 32'(mis && (b == 0)));
`endif
            if (abort == 2 && b == nb - 1) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_resp_cmd", 32'(command), 32'd0);
                chk("rst_resp_data", 32'(data), 32'd0);
                chk("rst_resp_busy", 32'(busy), 32'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end

        @(negedge clk);
        chk("post_cmd", 32'(command), 32'd0);
        chk("post_data", 32'(data), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [31:0] r_w;
        logic [31:0] r_rd;
        int          r_op;

        address            = '0;
        cpu_data_en        = 1'b0;
        cpu_cmd_en         = 1'b0;
        cpu_data           = '0;
        cpu_cmd            = '0;
        core_if.req_ready  = 1'b0;
        core_if.resp_valid = 1'b0;
        core_if.resp_rdata = '0;

        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_valid", 32'(core_if.req_valid), 32'd0);
        chk("reset_cmd_bus", 32'(command), 32'd0);
        chk("reset_data_bus", 32'(data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        do_txn(1, 19'h000E0, 16'h1234, 16'h0000, 32'h000000F0, 0, 0, 0);

        // Opcode present only on the turnaround edge must be ignored
        cpu_cmd_en = 1'b1;
        cpu_cmd    = 3'd1;
        @(posedge clk); #1;
        cpu_cmd_en = 1'b0;
        @(negedge clk);
        chk("turnaround_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        chk("turnaround_still_idle", 32'(busy), 32'd0);

        do_txn(7, 19'h000E0, 16'h5555, 16'h5555, 32'hDEADBEEF, 0, 0, 0);
        do_txn(3, 19'h002E0, 16'h0BAD, 16'h0F00, 32'hFF1998FF, 0, 0, 0);
        do_txn(4, 19'h00110, 16'hA5A5, 16'h3C3C, 32'hCAFEF00D, 5, 2, 0);

        // resp_valid while idle is ignored
        @(posedge clk); #1;
        core_if.resp_valid = 1'b1;
        core_if.resp_rdata = 32'h12345678;
        @(posedge clk); #1;
        core_if.resp_valid = 1'b0;
        @(negedge clk);
        chk("idle_resp_cmd", 32'(command), 32'd0);
        chk("idle_resp_busy", 32'(busy), 32'd0);

        do_txn(3, 19'h002E0, 16'h1111, 16'h2222, 32'h87654321, 0, 3, 1);
        do_txn(2, 19'h000E2, 16'h7777, 16'h8888, 32'h0000ABCD, 0, 0, 0);
        do_txn(3, 19'h00120, 16'h3333, 16'h4444, 32'h11223344, 1, 1, 2);
        do_txn(5, 19'h7FFFF, 16'hFFFF, 16'hFFFF, 32'h9ABCDEF0, 2, 0, 0);
`ifdef C1_ALIGN_CHECK_EN
        do_txn(2, 19'h000E1, 16'h0101, 16'h0202, 32'h00001234, 0, 0, 0);
        do_txn(7, 19'h000E2, 16'h0303, 16'h0404, 32'h00005678, 0, 0, 0);
`endif

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            r_op   = int'($urandom_range(1, 7));
            r_addr = $urandom();
            r_w    = $urandom();
            r_rd   = $urandom();
            do_txn(r_op, r_addr[18:0], r_w[15:0], r_w[31:16], r_rd,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
